// File: rtl/instr_seq_pkg.sv
// Shared encodings for the MSP430 instruction sequencer:
// sequencer states, MAB source codes, constant-generator registers.
package instr_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_FETCH,
    SEQ_SRC_EXT,
    SEQ_SRC_RD,
    SEQ_DST_EXT,
    SEQ_DST_RD,
    SEQ_EXEC,
    SEQ_DST_WR,
    SEQ_HALT
  } seq_state_t;

  localparam logic [1:0] MAB_SEL_PC  = 2'd0;
  localparam logic [1:0] MAB_SEL_SRC = 2'd1;
  localparam logic [1:0] MAB_SEL_DST = 2'd2;

  localparam logic [3:0] REG_PC = 4'd0;
  localparam logic [3:0] REG_SP = 4'd1;
  localparam logic [3:0] CG1    = 4'd2;
  localparam logic [3:0] CG2    = 4'd3;

  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_BIT = 4'hB;

  localparam logic [5:0] FMT2_PFX = 6'b000100;

  // R3 is a constant for every As; R2 only for As=10/11
  function automatic logic is_cg(
    input logic [3:0] rn,
    input logic [1:0] as_f
  );
    return (rn == CG2) || ((rn == CG1) && as_f[1]);
  endfunction

endpackage

// File: rtl/instr_seq_mode.sv
// Combinational addressing-mode classifier for one instruction word.
// Decides which bus phases the sequencer must walk through.
module instr_seq_mode
  import instr_seq_pkg::*;
(
  input  logic [15:0] i_instr,
  output logic        need_src_ext,
  output logic        need_src_rd,
  output logic        need_dst_ext,
  output logic        need_dst_rd,
  output logic        need_wr,
  output logic        is_jump,
  output logic        illegal,
  output logic        autoinc,
  output logic        o_fmt2,
  output logic        o_reg_we,
  output logic [1:0]  o_inc_amt
);

  logic [3:0] w_op;
  logic [3:0] w_sreg;
  logic [1:0] w_as;
  logic       w_ad;
  logic       w_bw;
  logic       w_jump;
  logic       w_fmt1;
  logic       w_fmt2;
  logic       w_cg;
  logic       w_nowb;

  assign w_op   = i_instr[15:12];
  assign w_as   = i_instr[5:4];
  assign w_ad   = i_instr[7];
  assign w_bw   = i_instr[6];
  assign w_jump = (i_instr[15:13] == 3'b001);
  assign w_fmt1 = (w_op >= 4'h4);
  // RRC/SWPB/RRA/SXT only; PUSH/CALL/RETI are unsupported
  assign w_fmt2 = (i_instr[15:10] == FMT2_PFX) & ~i_instr[9];
  assign w_sreg = w_fmt2 ? i_instr[3:0] : i_instr[11:8];
  assign w_cg   = is_cg(w_sreg, w_as);
  assign w_nowb = (w_op == OP_CMP) || (w_op == OP_BIT);

  always_comb begin
    need_src_ext = 1'b0;
    need_src_rd  = 1'b0;
    need_dst_ext = 1'b0;
    need_dst_rd  = 1'b0;
    need_wr      = 1'b0;
    autoinc      = 1'b0;
    o_reg_we     = 1'b0;
    is_jump      = w_jump;
    o_fmt2       = w_fmt2;
    illegal      = ~(w_jump | w_fmt1 | w_fmt2);
    o_inc_amt    = (w_bw && w_sreg != REG_PC &&
                    w_sreg != REG_SP) ? 2'd1 : 2'd2;
    if (w_fmt1 || w_fmt2) begin
      if (!w_cg) begin
        case (w_as)
          2'b01: begin
            need_src_ext = 1'b1;
            need_src_rd  = 1'b1;
          end
          2'b10: need_src_rd = 1'b1;
          2'b11: begin
            if (w_sreg == REG_PC) begin
              need_src_ext = 1'b1;
            end else begin
              need_src_rd = 1'b1;
              autoinc     = 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (w_fmt1) begin
        need_dst_ext = w_ad;
        need_dst_rd  = w_ad & (w_op != OP_MOV);
        need_wr      = w_ad & ~w_nowb;
        o_reg_we     = ~w_ad & ~w_nowb;
      end else begin
        // single operand is both source and destination
        need_wr  = need_src_rd;
        o_reg_we = (w_as == 2'b00);
      end
    end
  end

endmodule

// File: rtl/instr_seq.sv
// MSP430 instruction micro-sequencer: IR, extension words, bus strobes.
// Optional memory timeout when INSTR_SEQ_TIMEOUT_EN is defined.
module instr_seq
  import instr_seq_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int BUS_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] mdb_in,
  input  logic             mem_rdy,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mab_sel,
  output logic             pc_inc,
  output logic [15:0]      ir,
  output logic [15:0]      ext_src,
  output logic [15:0]      ext_dst,
  output logic             src_ld,
  output logic             dst_ld,
  output logic             exec,
  output logic             reg_we,
  output logic             sreg_inc,
  output logic [1:0]       inc_amt,
  output logic             ill_op,
  output logic             bus_err
);

  seq_state_t  r_state;
  logic [15:0] r_ir;
  logic [15:0] r_ext_src;
  logic [15:0] r_ext_dst;
  logic        r_ill_op;

  logic [15:0] w_word;
  logic        w_src_ext;
  logic        w_src_rd;
  logic        w_dst_ext;
  logic        w_dst_rd;
  logic        w_wr;
  logic        w_jump;
  logic        w_illegal;
  logic        w_autoinc;
  logic        w_fmt2;
  logic        w_reg_we;
  logic [1:0]  w_inc_amt;
  seq_state_t  w_dst_step;

  // classify the word on the bus while fetching, the IR afterwards
  assign w_word = (r_state == SEQ_FETCH) ? mdb_in[15:0] : r_ir;

  instr_seq_mode u_mode (
    .i_instr      (w_word),
    .need_src_ext (w_src_ext),
    .need_src_rd  (w_src_rd),
    .need_dst_ext (w_dst_ext),
    .need_dst_rd  (w_dst_rd),
    .need_wr      (w_wr),
    .is_jump      (w_jump),
    .illegal      (w_illegal),
    .autoinc      (w_autoinc),
    .o_fmt2       (w_fmt2),
    .o_reg_we     (w_reg_we),
    .o_inc_amt    (w_inc_amt)
  );

  assign w_dst_step = w_dst_ext ? SEQ_DST_EXT : SEQ_EXEC;

`ifdef INSTR_SEQ_TIMEOUT_EN
  localparam int WCW = $clog2(WAIT_MAX + 2);
  logic [WCW-1:0] r_wait;
  logic           r_bus_err;
  assign bus_err = r_bus_err;
`else
  assign bus_err = (WAIT_MAX < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SEQ_FETCH;
      r_ir      <= 16'h0000;
      r_ext_src <= 16'h0000;
      r_ext_dst <= 16'h0000;
      r_ill_op  <= 1'b0;
`ifdef INSTR_SEQ_TIMEOUT_EN
      r_wait    <= '0;
      r_bus_err <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        SEQ_FETCH: if (mem_rdy) begin
          r_ir <= mdb_in[15:0];
          if (w_illegal) begin
            r_ill_op <= 1'b1;
            r_state  <= SEQ_HALT;
          end else if (w_jump)
            r_state <= SEQ_EXEC;
          else if (w_src_ext)
            r_state <= SEQ_SRC_EXT;
          else if (w_src_rd)
            r_state <= SEQ_SRC_RD;
          else
            r_state <= w_dst_step;
        end
        SEQ_SRC_EXT: if (mem_rdy) begin
          r_ext_src <= mdb_in[15:0];
          r_state   <= w_src_rd ? SEQ_SRC_RD : w_dst_step;
        end
        SEQ_SRC_RD: if (mem_rdy)
          r_state <= w_dst_step;
        SEQ_DST_EXT: if (mem_rdy) begin
          r_ext_dst <= mdb_in[15:0];
          r_state   <= w_dst_rd ? SEQ_DST_RD : SEQ_EXEC;
        end
        SEQ_DST_RD: if (mem_rdy)
          r_state <= SEQ_EXEC;
        SEQ_EXEC:
          r_state <= w_wr ? SEQ_DST_WR : SEQ_FETCH;
        SEQ_DST_WR: if (mem_rdy)
          r_state <= SEQ_FETCH;
        SEQ_HALT:
          r_state <= SEQ_HALT;
      endcase
`ifdef INSTR_SEQ_TIMEOUT_EN
      if (mem_req && !mem_rdy) begin
        r_wait <= r_wait + WCW'(1);
        if (r_wait == WCW'(WAIT_MAX)) begin
          r_bus_err <= 1'b1;
          r_state   <= SEQ_HALT;
        end
      end else if (mem_req) begin
        r_wait <= '0;
      end
`endif
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mab_sel  = MAB_SEL_PC;
    pc_inc   = 1'b0;
    src_ld   = 1'b0;
    dst_ld   = 1'b0;
    exec     = 1'b0;
    reg_we   = 1'b0;
    sreg_inc = 1'b0;
    inc_amt  = 2'd0;
    unique case (r_state)
      SEQ_FETCH, SEQ_SRC_EXT, SEQ_DST_EXT: begin
        mem_req = 1'b1;
        pc_inc  = mem_rdy;
      end
      SEQ_SRC_RD: begin
        mem_req  = 1'b1;
        mab_sel  = MAB_SEL_SRC;
        src_ld   = mem_rdy;
        sreg_inc = mem_rdy & w_autoinc;
        inc_amt  = (mem_rdy & w_autoinc) ? w_inc_amt : 2'd0;
      end
      SEQ_DST_RD: begin
        mem_req = 1'b1;
        mab_sel = MAB_SEL_DST;
        dst_ld  = mem_rdy;
      end
      SEQ_EXEC: begin
        exec   = 1'b1;
        reg_we = w_reg_we & ~w_jump;
      end
      SEQ_DST_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        mab_sel = w_fmt2 ? MAB_SEL_SRC : MAB_SEL_DST;
      end
      SEQ_HALT: ;
    endcase
  end

  assign ir      = r_ir;
  assign ext_src = r_ext_src;
  assign ext_dst = r_ext_dst;
  assign ill_op  = r_ill_op;

endmodule

// File: doc/instr_seq.md
Name: instr_seq

Overview:
- Central micro-sequencer for the MSP430 core.
- Owns the instruction register and steps each instruction through fetch, extension-word fetch, operand read, execute and memory write-back.
- Drives MAB source select, PC increment, operand latch strobes and memory handshake.
- instr_dec consumes ir and the per-phase strobes; the datapath acts only on those strobes.

Parameters:
- WAIT_MAX, 15: max consecutive cycles mem_rdy may stay low before bus_err (timeout feature only).
- BUS_W, 16: MDB/MAB width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- mdb_in  in  BUS_W  memory data bus, read data.
- mem_rdy  in  1  memory accepts/returns the current access this cycle.
- mem_req  out  1  memory access requested this cycle.
- mem_we  out  1  current access is a write.
- mab_sel  out  2  MAB source: 0 PC, 1 src address (Rn+ext / @Rn), 2 dst address (Rn+ext), 3 reserved.
- pc_inc  out  1  PC += 2 this cycle.
- ir  out  16  instruction register.
- ext_src  out  16  latched source extension word.
- ext_dst  out  16  latched destination extension word.
- src_ld  out  1  latch MDB into source operand register.
- dst_ld  out  1  latch MDB into destination operand register.
- exec  out  1  ALU/flags evaluate this cycle.
- reg_we  out  1  register-file write this cycle.
- sreg_inc  out  1  auto-increment source register.
- inc_amt  out  2  increment amount, 1 or 2.
- ill_op  out  1  illegal/unsupported opcode, sticky.
- bus_err  out  1  memory timeout, sticky.

Behaviour:
- States: FETCH, SRC_EXT, SRC_RD, DST_EXT, DST_RD, EXEC, DST_WR, HALT. Reset state FETCH.
- Reset values: ir=0, ext_src=0, ext_dst=0, all strobes 0, ill_op=0, bus_err=0.
- Asynchronous reset mid-instruction aborts immediately. No mem_we is asserted after rst rises.
- Memory handshake:
  - In FETCH, SRC_EXT, SRC_RD, DST_EXT, DST_RD and DST_WR: mem_req=1.
  - A state advances only on a clock edge where mem_rdy=1; otherwise it holds and all strobes stay 0.
  - Data is captured on that same edge.
- PC increment: pc_inc=mem_req&mem_rdy in FETCH, SRC_EXT and DST_EXT only, so exactly one pulse per word accepted.
- FETCH: ir<=mdb_in. Next state is decided from mdb_in:
  - Jump (15:13=001): go to EXEC.
  - Format I (15:12>=4) or Format II RRC/SWPB/RRA/SXT: go to the source step.
  - Format II PUSH/CALL/RETI, 15:12=0, or any other unsupported opcode: set ill_op, go to HALT.
- Source step, from As and src reg (Format II uses its single operand as src):
  - Constant-generator cases go straight to the dst step with no access: R3 any As; R2 As=10/11.
  - As=00: register operand, no access.
  - As=01: SRC_EXT then SRC_RD (R2 means absolute, base 0).
  - As=10: SRC_RD.
  - As=11 with R0: SRC_EXT only; immediate, ext_src is the operand.
  - As=11 with other Rn: SRC_RD with sreg_inc=1 on accept. inc_amt=1 if BW=1 and Rn not R0/R1, else 2.
- Dst step:
  - Format I with Ad=1: DST_EXT, then DST_RD, except MOV, which skips DST_RD.
  - Ad=0: EXEC.
  - Format II: the operand is the dst. Memory modes write back through DST_WR using the src address, mab_sel=1.
- EXEC: single cycle, exec=1.
  - reg_we=1 iff the destination is a register and the op is not CMP/BIT/jump.
  - For memory destinations, EXEC then DST_WR with mem_we=1, except CMP/BIT, which return to FETCH.
- DST_WR: mem_we=1 until mem_rdy, then FETCH.
- mab_sel: 0 in FETCH/SRC_EXT/DST_EXT; 1 in SRC_RD; 2 in DST_RD/DST_WR; 1 for Format II write-back.
- Cycle counts with zero wait states: reg-reg 2; immediate-src 3; indexed-dst ADD 5.
- HALT: all strobes 0, mem_req=0. Exit only through rst.

Optional Feature:
- INSTR_SEQ_TIMEOUT_EN defined:
  - A 4-bit+ wait counter counts cycles with mem_req=1 and mem_rdy=0, and clears on accept.
  - When it reaches WAIT_MAX+1: bus_err<=1, state goes to HALT.
- Not defined: the sequencer waits indefinitely, bus_err is tied 0 and no counter is synthesised.

Decomposition:
- Extend msp430_ops.vh with:
  - state encodings (SEQ_FETCH…SEQ_HALT);
  - MAB_SEL_* codes;
  - CG register numbers (CG1=R2, CG2=R3).
- One sub-module, instr_seq_mode: combinational addressing-mode classifier from ir/mdb_in. Outputs need_src_ext, need_src_rd, need_dst_ext, need_dst_rd, need_wr, is_jump, illegal, autoinc.

Test Plan:
- MOV R4,R5 (0x4405), mem_rdy=1 → FETCH→EXEC; pc_inc 1 pulse; reg_we=1 in EXEC; back in FETCH at cycle 3.
- ADD #0x1234,R6 (0x5036, then 0x1234) → FETCH, SRC_EXT, EXEC; ext_src=0x1234; 2 pc_inc pulses; no SRC_RD.
- ADD R5,2(R6) (0x5586, then 0x0002) → FETCH, DST_EXT, DST_RD, EXEC, DST_WR; ext_dst=0x0002; mab_sel=2 in DST_RD/DST_WR; mem_we for 1 cycle; reg_we=0.
- MOV.B @R5+,R6 (0x4576) → SRC_RD with sreg_inc=1, inc_amt=1; mem_rdy low 3 cycles in SRC_RD → state holds, sreg_inc pulses once.
- ir=0x0000 → ill_op=1, HALT, mem_req=0. With INSTR_SEQ_TIMEOUT_EN, mem_rdy=0 for 16 cycles in FETCH → bus_err=1.
- rst asserted mid-DST_WR → mem_we drops asynchronously; state FETCH and ir=0 after release.
